audio_i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_bclk_gen.sv | 41 ++++
 rtl/audio_i2s_tx.sv | 144 ++++++++++++++
 tb/tb_audio_i2s_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the player / I2S transmitter pair.
package audio_pkg;

    // Default PCM sample width used across the audio path
    localparam int unsigned DataWidthDefault = 16;

    // I2S word-select encoding
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/audio_bclk_gen.sv
// I2S bit-clock generator: divides clk down to BCLK and flags each 1->0 toggle
// one cycle ahead so the transmitter can update data on the same edge.
module audio_bclk_gen #(
    parameter int unsigned BclkHalf = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic halt,
    output logic aud_bclk,
    output logic fall
);

    localparam int unsigned DivW = (BclkHalf > 1) ? $clog2(BclkHalf) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(BclkHalf - 1);

    logic [DivW-1:0] div_q;
    logic            bclk_q;
    logic            wrap;

    assign wrap     = !halt && (div_q == DivMax);
    // Asserted in the cycle whose closing edge takes BCLK from 1 to 0
    assign fall     = wrap && bclk_q;
    assign aud_bclk = bclk_q;

    // Half-period divider; halt parks the divider and BCLK low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (halt) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (wrap) begin
            div_q  <= '0;
            bclk_q <= !bclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: one-entry sample buffer, frame shifter and run/idle FSM.
// Each accepted sample is sent MSB-first in both the left and right slot.
module audio_i2s_tx #(
    parameter int unsigned DataWidth = audio_pkg::DataWidthDefault,
    parameter int unsigned SlotWidth = 16,
    parameter int unsigned BclkHalf  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DataWidth-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 aud_bclk,
    output logic                 aud_daclrck,
    output logic                 aud_dacdat,
    output logic                 frame_start,
    output logic                 underrun
);

    import audio_pkg::*;

    localparam int unsigned FrameBits = 2 * SlotWidth;
    localparam int unsigned CntW      = $clog2(FrameBits);
    localparam int unsigned PosW      = (SlotWidth > 1) ? $clog2(SlotWidth) : 1;
    localparam int unsigned Pad       = SlotWidth - DataWidth;
    localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);
    localparam logic [CntW-1:0] SlotW   = CntW'(SlotWidth);

    state_e               state_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic                 buf_full_q;
    logic [DataWidth-1:0] buf_q;
    logic [DataWidth-1:0] last_q;
    logic [DataWidth-1:0] word_q;
    logic                 ready_q;
    logic                 lrck_q;
    logic                 dat_q;
    logic                 fs_q;
    logic                 ur_q;

    logic                 halt;
    logic                 fall;
    logic                 load;
    logic                 accept;
    logic                 buf_full_d;
    logic [CntW-1:0]      bit_next;
    logic [CntW-1:0]      lrck_idx;
    logic [CntW-1:0]      slot_pos;
    logic [PosW-1:0]      bit_idx;
    logic [DataWidth-1:0] word_now;
    logic [SlotWidth-1:0] slot_word;
    logic                 dat_bit;
    logic                 lrck_next;

    assign halt = (state_q == IDLE);

    audio_bclk_gen #(
        .BclkHalf (BclkHalf)
    ) u_bclk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .halt     (halt),
        .aud_bclk (aud_bclk),
        .fall     (fall)
    );

    // Bit position, slot word and serial bit for the upcoming fall event
    always_comb begin
        bit_next   = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + 1'b1;
        lrck_idx   = (bit_next == LastBit) ? '0 : bit_next + 1'b1;
        lrck_next  = (lrck_idx >= SlotW) ? RIGHT : LEFT;
        slot_pos   = (bit_next >= SlotW) ? bit_next - SlotW : bit_next;
        bit_idx    = PosW'(SlotWidth - 1) - PosW'(slot_pos);
        load       = fall && (bit_next == '0);
        accept     = sample_valid && !buf_full_q;
        // On a load the new word is visible on the same edge
        word_now   = load ? (buf_full_q ? buf_q : last_q) : word_q;
        slot_word  = SlotWidth'(word_now) << Pad;
        dat_bit    = slot_word[bit_idx];
        buf_full_d = accept ? 1'b1 : ((load && buf_full_q) ? 1'b0 : buf_full_q);
    end

    // Buffer, shifter and run/idle FSM with registered I2S outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= LastBit;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            last_q     <= '0;
            word_q     <= '0;
            ready_q    <= 1'b1;
            lrck_q     <= LEFT;
            dat_q      <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            buf_full_q <= buf_full_d;
            ready_q    <= !buf_full_d;
            if (accept) begin
                buf_q <= sample_in;
            end
            unique case (state_q)
                IDLE: begin
                    lrck_q <= LEFT;
                    dat_q  <= 1'b0;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (fall) begin
                        bit_cnt_q <= bit_next;
                        lrck_q    <= lrck_next;
                        dat_q     <= dat_bit;
                        if (load) begin
                            fs_q   <= 1'b1;
                            word_q <= word_now;
                            if (buf_full_q) begin
                                last_q <= buf_q;
                            end else begin
                                ur_q <= 1'b1;
                            end
                        end
                        // Leave only after the last right-slot bit so frames stay whole
                        if ((bit_next == LastBit) && !enable) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign sample_ready = ready_q;
    assign aud_daclrck  = lrck_q;
    assign aud_dacdat   = dat_q;
    assign frame_start  = fs_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    localparam int BH = 2;
    localparam int SW = 16;
    localparam int FB = 2 * SW;

    logic        clk;
    logic        reset_n, enable, sample_valid, sample_ready;
    logic [15:0] sample_in;
    logic        aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun;

    logic        reset_n12, enable12, sample_valid12, sample_ready12;
    logic [11:0] sample_in12;
    logic        bclk12, lrck12, dat12, fs12, ur12;

    int checks = 0;
    int errors = 0;

    audio_i2s_tx #(.DataWidth(16), .SlotWidth(SW), .BclkHalf(BH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .aud_bclk(aud_bclk),
        .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat), .frame_start(frame_start),
        .underrun(underrun)
    );

    audio_i2s_tx #(.DataWidth(12), .SlotWidth(SW), .BclkHalf(BH)) dut12 (
        .clk(clk), .reset_n(reset_n12), .enable(enable12), .sample_in(sample_in12),
        .sample_valid(sample_valid12), .sample_ready(sample_ready12), .aud_bclk(bclk12),
        .aud_daclrck(lrck12), .aud_dacdat(dat12), .frame_start(fs12), .underrun(ur12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot-word bit at frame position b: sample MSB-first, zero padded below DataWidth
    function automatic logic exp_bit(input logic [15:0] w, input int b, input int dw);
        int pos = b % SW;
        if (pos < dw) return w[dw-1-pos];
        return 1'b0;
    endfunction

    // ---------------- scoreboard: accepted samples in order ----------------
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } acc_t;
    acc_t acc_q[$];
    int   cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) acc_q.delete();
            else if (sample_valid && sample_ready) acc_q.push_back('{sample_in, cyc});
            cyc = cyc + 1;
        end
    end

    // ---------------- monitor: frame/bit reference model ----------------
    int          mon_b = FB - 1;
    int          mon_falls = 0;
    int          fs_count = 0;
    int          ur_count = 0;
    int          fs_cyc = 0;
    int          last_fall_cyc = 0;
    logic        prev_bclk = 1'b0;
    logic [15:0] last_word = '0;
    logic [15:0] cur_word = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_b     = FB - 1;
                prev_bclk = 1'b0;
                last_word = '0;
            end else begin
                if (prev_bclk && !aud_bclk) begin
                    int   b;
                    logic exp_ur;
                    b = (mon_b + 1) % FB;
                    check("frame_start_at_b0", frame_start, (b == 0));
                    if (b == 0) begin
                        // Sample accepted on the load edge itself stays in the buffer
                        if (acc_q.size() > 0 && acc_q[0].cyc < cyc - 1) begin
                            last_word = acc_q.pop_front().data;
                            exp_ur    = 1'b0;
                        end else begin
                            exp_ur    = 1'b1;
                        end
                        cur_word = last_word;
                        check("underrun", underrun, exp_ur);
                        fs_count++;
                        ur_count += int'(underrun);
                        fs_cyc = cyc - 1;
                    end else begin
                        check("fall_spacing", cyc - last_fall_cyc, 2 * BH);
                    end
                    check("dacdat", aud_dacdat, exp_bit(cur_word, b, 16));
                    check("daclrck", aud_daclrck, ((b + 1) % FB) / SW);
                    mon_b         = b;
                    last_fall_cyc = cyc;
                    mon_falls++;
                end else begin
                    check("no_frame_start", frame_start, 0);
                    check("no_underrun", underrun, 0);
                end
                prev_bclk = aud_bclk;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [15:0] d);
        int   n = 0;
        logic rdy;
        @(negedge clk);
        sample_in    = d;
        sample_valid = 1'b1;
        forever begin
            rdy = sample_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 2000) begin
                check("push_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
        #1 sample_valid = 1'b0;
    endtask

    task automatic wait_fs(input int more);
        int start = fs_count;
        int n = 0;
        while (fs_count < start + more) begin
            @(negedge clk);
            #2;
            n++;
            if (n > 1000 * more) begin
                check("frame_start_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic wait_fall_b(input int target);
        int start = mon_falls;
        int n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_falls > start && mon_b == target) break;
            n++;
            if (n > 1000) begin
                check("fall_wait_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic stop_run();
        int fs0;
        int bad = 0;
        wait_fall_b(5);
        enable = 1'b0;
        fs0 = fs_count;
        wait_fall_b(FB - 1);
        repeat (2) @(negedge clk);
        repeat (200) begin
            @(negedge clk);
            if (aud_bclk || aud_daclrck || aud_dacdat || frame_start) bad++;
        end
        check("idle_after_disable", bad, 0);
        check("no_frame_after_disable", fs_count, fs0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s, fs1, acc_c, ur0, bad, nf;
        logic p12;

        reset_n = 0; enable = 0; sample_valid = 0; sample_in = '0;
        reset_n12 = 0; enable12 = 0; sample_valid12 = 0; sample_in12 = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bclk", aud_bclk, 0);
        check("rst_lrck", aud_daclrck, 0);
        check("rst_dat", aud_dacdat, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_fs", frame_start, 0);
        check("rst_ur", underrun, 0);
        @(negedge clk);
        reset_n = 1; reset_n12 = 1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (aud_bclk) bad++;
        end
        check("bclk_idle_100", bad, 0);

        // Single frame, latency and frame length
        push(16'hA5C3);
        @(negedge clk);
        #1 check("ready_low_when_full", sample_ready, 0);
        @(negedge clk);
        enable = 1'b1;
        s = cyc;
        wait_fs(1);
        check("first_fall_latency", fs_cyc - s, 2 * BH);
        fs1 = fs_cyc;

        // Backpressure: second push waits until the next frame load frees the buffer
        push(16'h1234);
        push(16'h5678);
        acc_c = cyc - 1;
        check("held_until_load", acc_c, fs_cyc + 1);
        check("frame_len", fs_cyc - fs1, 2 * FB * BH);
        push(16'h9ABC);
        ur0 = ur_count;
        wait_fs(2);
        check("underrun_after_drain", ur_count - ur0, 1);
        stop_run();

        // Underrun repeats the last sample
        push(16'h00FF);
        ur0 = ur_count;
        @(negedge clk);
        enable = 1'b1;
        wait_fs(2);
        check("underrun_once", ur_count - ur0, 1);
        check("underrun_word", cur_word, 16'h00FF);
        stop_run();

        // Randomised traffic with random gaps
        @(negedge clk);
        enable = 1'b1;
        repeat (30) begin
            repeat ($urandom_range(0, 160)) @(negedge clk);
            push(16'($urandom));
        end
        stop_run();

        // 12-bit samples in 16-bit slots
        @(negedge clk);
        sample_in12 = 12'hFFF;
        sample_valid12 = 1'b1;
        @(posedge clk);
        #1 sample_valid12 = 1'b0;
        enable12 = 1'b1;
        p12 = 1'b0;
        nf = 0;
        for (int n = 0; n < 1000 && nf < FB + 21; n++) begin
            @(negedge clk);
            if (p12 && !bclk12) begin
                if (nf == 0) check("pad_frame_start", fs12, 1);
                if (nf < FB) begin
                    check("pad_dat", dat12, exp_bit(16'h0FFF, nf, 12));
                    check("pad_lrck", lrck12, ((nf + 1) % FB) / SW);
                end
                nf++;
            end
            p12 = bclk12;
        end
        check("pad_fall_count", nf, FB + 21);
        // Now just after b=20 of frame 2; let BCLK rise, then reset mid-slot
        repeat (2) @(negedge clk);
        check("pre_reset_lrck", lrck12, 1);
        check("pre_reset_bclk", bclk12, 1);
        #1 reset_n12 = 1'b0;
        #1;
        check("mid_reset_bclk", bclk12, 0);
        check("mid_reset_lrck", lrck12, 0);
        check("mid_reset_dat", dat12, 0);
        check("mid_reset_ready", sample_ready12, 1);
        check("mid_reset_fs", fs12, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
